// File: rtl/mem_bus_arbiter.sv
// Two-master memory bus arbiter (ICache m0 read-only, DCache m1 read/write) with burst-length grants.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking; the default build gives m1 fixed priority.
module mem_bus_arbiter #(
    parameter int BUS_WIDTH = 32,
    parameter int CPU_WIDTH = 32,
    parameter int BURST_LEN = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   m0_ce,
    input  logic                   m1_ce,
    input  logic                   m0_we,
    input  logic                   m1_we,
    input  logic [BUS_WIDTH-1:0]   m0_addr,
    input  logic [BUS_WIDTH-1:0]   m1_addr,
    input  logic [CPU_WIDTH-1:0]   m1_wdata,
    input  logic [CPU_WIDTH/8-1:0] m1_wmask,
    output logic [CPU_WIDTH-1:0]   m0_rdata,
    output logic [CPU_WIDTH-1:0]   m1_rdata,
    output logic                   m0_rdata_valid,
    output logic                   m1_rdata_valid,
    output logic                   m1_write_respone,
    output logic [BUS_WIDTH-1:0]   mem_addr,
    input  logic [CPU_WIDTH-1:0]   mem_rdata,
    input  logic                   mem_rdata_valid,
    output logic [CPU_WIDTH-1:0]   mem_wdata,
    output logic [CPU_WIDTH/8-1:0] mem_wmask,
    input  logic                   mem_write_respone,
    output logic                   mem_ce,
    output logic                   mem_we,
    output logic [1:0]             grant
);

    localparam int CNT_W = $clog2(BURST_LEN) + 1;

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
    logic             beat;
    logic             last_beat;
    logic             tie_to_m1;

    // The ICache is read-only, so its write enable is deliberately unused.
    logic unused_m0_we;
    assign unused_m0_we = m0_we;

    assign beat      = mem_rdata_valid | mem_write_respone;
    assign last_beat = beat && (beat_cnt == CNT_W'(BURST_LEN - 1));

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // last_grant: 1 = m1 was granted most recently; reset value lets m0 win the first tie.
    logic last_grant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
        end else if (state == IDLE && state_nxt != IDLE) begin
            last_grant <= (state_nxt == GNT1);
        end
    end

    assign tie_to_m1 = ~last_grant;
`else
    assign tie_to_m1 = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        case (state)
            IDLE: begin
                if (m0_ce && m1_ce) begin
                    state_nxt = tie_to_m1 ? GNT1 : GNT0;
                end else if (m1_ce) begin
                    state_nxt = GNT1;
                end else if (m0_ce) begin
                    state_nxt = GNT0;
                end
            end
            GNT0: begin
                // Dropping ce aborts the burst; the final beat always returns through IDLE.
                if (!m0_ce || last_beat) begin
                    state_nxt    = IDLE;
                    beat_cnt_nxt = '0;
                end else if (beat) begin
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                end
            end
            GNT1: begin
                if (!m1_ce || last_beat) begin
                    state_nxt    = IDLE;
                    beat_cnt_nxt = '0;
                end else if (beat) begin
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt    = IDLE;
                beat_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        grant     = 2'b00;
        case (state)
            GNT0: begin
                mem_ce   = m0_ce;
                mem_addr = m0_addr;
                grant    = 2'b01;
            end
            GNT1: begin
                mem_ce    = m1_ce;
                mem_we    = m1_we;
                mem_addr  = m1_addr;
                mem_wdata = m1_wdata;
                mem_wmask = m1_wmask;
                grant     = 2'b10;
            end
            default: ;
        endcase
    end

    assign m0_rdata         = mem_rdata;
    assign m1_rdata         = mem_rdata;
    assign m0_rdata_valid   = mem_rdata_valid & grant[0];
    assign m1_rdata_valid   = mem_rdata_valid & grant[1];
    assign m1_write_respone = mem_write_respone & grant[1];

endmodule
